ddr3_init_seq: RTL and testbench

DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

---
 rtl/ddr3_init_seq.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_ddr3_init_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up / re-initialisation sequencer.
// Walks RESET# hold, CKE wait, XPR, per-rank MRS2/3/1/0 + ZQCL, then idles in
// DONE where it serves re-init and ZQCS short-calibration requests.
// All pins are registered; the command decode looks at the next state so each
// pin changes on the same edge as the state that owns it.
module ddr3_init_seq #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned NUM_RANKS = 1,
  parameter int unsigned T_RESET   = 80000,
  parameter int unsigned T_CKE     = 200000,
  parameter int unsigned T_XPR     = 108,
  parameter int unsigned T_MRD     = 4,
  parameter int unsigned T_MOD     = 12,
  parameter int unsigned T_ZQINIT  = 512,
  parameter int unsigned T_ZQCS    = 64,
  parameter logic [ADDR_BITS-1:0] MR0 = ADDR_BITS'(16'h0522),
  parameter logic [ADDR_BITS-1:0] MR1 = ADDR_BITS'(16'h0044),
  parameter logic [ADDR_BITS-1:0] MR2 = ADDR_BITS'(16'h0000),
  parameter logic [ADDR_BITS-1:0] MR3 = ADDR_BITS'(16'h0000)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 init_req,
  input  logic                 zq_req,
  output logic                 zq_ack,
  output logic                 ddr_reset_n,
  output logic                 cke,
  output logic [NUM_RANKS-1:0] cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] a,
  output logic                 odt,
  output logic                 init_done,
  output logic                 busy
);

  typedef enum logic [3:0] {
    RST_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0,
    MOD_WAIT, ZQCL, ZQ_WAIT, DONE, ZQCS, ZQCS_WAIT
  } state_t;

  // Counter load values: duration-1; the wait states following a one-cycle
  // command last duration-1 cycles, so they load duration-2.
  localparam logic [31:0] LD_RESET  = 32'(T_RESET - 1);
  localparam logic [31:0] LD_CKE    = 32'(T_CKE - 1);
  localparam logic [31:0] LD_XPR    = 32'(T_XPR - 1);
  localparam logic [31:0] LD_MRD    = 32'(T_MRD - 1);
  localparam logic [31:0] LD_MOD    = 32'(T_MOD - 2);
  localparam logic [31:0] LD_ZQINIT = 32'(T_ZQINIT - 2);
  localparam logic [31:0] LD_ZQCS   = 32'(T_ZQCS - 2);
  localparam logic [1:0]  LAST_RANK = 2'(NUM_RANKS - 1);

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [1:0]             r_q, r_d;
  // Clear while rst is high: the first edge after release is then the
  // RESET# hold entry edge and loads the hold duration.
  logic                   arm_q, arm_d;

  logic                   zq_ack_q, zq_ack_d;
  logic                   ddr_reset_n_q, ddr_reset_n_d;
  logic                   cke_q, cke_d;
  logic [NUM_RANKS-1:0]   cs_n_q, cs_n_d;
  logic                   ras_n_q, ras_n_d;
  logic                   cas_n_q, cas_n_d;
  logic                   we_n_q, we_n_d;
  logic [BA_BITS-1:0]     ba_q, ba_d;
  logic [ADDR_BITS-1:0]   a_q, a_d;
  logic                   init_done_q, init_done_d;
  logic                   busy_q;
  logic                   odt_q;

  // Active-low chip select pattern addressing a single rank.
  function automatic logic [NUM_RANKS-1:0] rank_sel(input logic [1:0] r);
    logic [NUM_RANKS-1:0] sel;
    for (int i = 0; i < NUM_RANKS; i++) begin
      sel[i] = (2'(i) != r);
    end
    return sel;
  endfunction

  // Next-state / counter / rank sequencing followed by registered-pin decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != 32'd0) ? (cnt_q - 32'd1) : 32'd0;
    r_d      = r_q;
    arm_d    = arm_q;
    zq_ack_d = 1'b0;

    case (state_q)
      RST_HOLD: begin
        if (!arm_q) begin
          cnt_d = LD_RESET;
          arm_d = 1'b1;
        end else if (cnt_q == 32'd0) begin
          state_d = CKE_WAIT;
          cnt_d   = LD_CKE;
        end else begin
          state_d = RST_HOLD;
        end
      end
      CKE_WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = XPR;
          cnt_d   = LD_XPR;
        end else begin
          state_d = CKE_WAIT;
        end
      end
      XPR: begin
        if (cnt_q == 32'd0) begin
          state_d = MRS2;
          cnt_d   = LD_MRD;
        end else begin
          state_d = XPR;
        end
      end
      MRS2: begin
        if (cnt_q == 32'd0) begin
          state_d = MRS3;
          cnt_d   = LD_MRD;
        end else begin
          state_d = MRS2;
        end
      end
      MRS3: begin
        if (cnt_q == 32'd0) begin
          state_d = MRS1;
          cnt_d   = LD_MRD;
        end else begin
          state_d = MRS3;
        end
      end
      MRS1: begin
        if (cnt_q == 32'd0) begin
          state_d = MRS0;
          cnt_d   = 32'd0;
        end else begin
          state_d = MRS1;
        end
      end
      MRS0: begin
        state_d = MOD_WAIT;
        cnt_d   = LD_MOD;
      end
      MOD_WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = ZQCL;
          cnt_d   = 32'd0;
        end else begin
          state_d = MOD_WAIT;
        end
      end
      ZQCL: begin
        state_d = ZQ_WAIT;
        cnt_d   = LD_ZQINIT;
      end
      ZQ_WAIT: begin
        if (cnt_q != 32'd0) begin
          state_d = ZQ_WAIT;
        end else if (r_q == LAST_RANK) begin
          state_d = DONE;
          cnt_d   = 32'd0;
        end else begin
          state_d = MRS2;
          cnt_d   = LD_MRD;
          r_d     = r_q + 2'd1;
        end
      end
      DONE: begin
        // Re-init has priority over a concurrent calibration request.
        if (init_req) begin
          state_d = RST_HOLD;
          cnt_d   = LD_RESET;
          r_d     = 2'd0;
        end else if (zq_req) begin
          state_d  = ZQCS;
          cnt_d    = 32'd0;
          zq_ack_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      ZQCS: begin
        state_d = ZQCS_WAIT;
        cnt_d   = LD_ZQCS;
      end
      ZQCS_WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = DONE;
          cnt_d   = 32'd0;
        end else begin
          state_d = ZQCS_WAIT;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = 32'd0;
        r_d     = 2'd0;
        arm_d   = 1'b0;
      end
    endcase

    // Pin decode: DESELECT unless the upcoming state drives something else.
    ddr_reset_n_d = 1'b1;
    cke_d         = 1'b1;
    cs_n_d        = {NUM_RANKS{1'b1}};
    ras_n_d       = 1'b1;
    cas_n_d       = 1'b1;
    we_n_d        = 1'b1;
    ba_d          = {BA_BITS{1'b0}};
    a_d           = {ADDR_BITS{1'b0}};
    init_done_d   = 1'b0;

    case (state_d)
      RST_HOLD: begin
        ddr_reset_n_d = 1'b0;
        cke_d         = 1'b0;
      end
      CKE_WAIT: begin
        cke_d = 1'b0;
      end
      XPR: begin
        cs_n_d = {NUM_RANKS{1'b0}};
      end
      MRS2, MRS3, MRS1: begin
        // Command only on the entry cycle; the rest of the tMRD gap deselects.
        if (cnt_d == LD_MRD) begin
          cs_n_d  = rank_sel(r_d);
          ras_n_d = 1'b0;
          cas_n_d = 1'b0;
          we_n_d  = 1'b0;
          if (state_d == MRS2) begin
            ba_d = BA_BITS'(2);
            a_d  = MR2;
          end else if (state_d == MRS3) begin
            ba_d = BA_BITS'(3);
            a_d  = MR3;
          end else begin
            ba_d = BA_BITS'(1);
            a_d  = MR1;
          end
        end else begin
          cs_n_d = {NUM_RANKS{1'b1}};
        end
      end
      MRS0: begin
        cs_n_d  = rank_sel(r_d);
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        we_n_d  = 1'b0;
        ba_d    = BA_BITS'(0);
        a_d     = MR0;
      end
      ZQCL: begin
        cs_n_d   = rank_sel(r_d);
        we_n_d   = 1'b0;
        a_d[10]  = 1'b1;
      end
      DONE: begin
        init_done_d = 1'b1;
      end
      ZQCS: begin
        cs_n_d = {NUM_RANKS{1'b0}};
        we_n_d = 1'b0;
      end
      default: begin
        cs_n_d = {NUM_RANKS{1'b1}};
      end
    endcase
  end

  // Sequencer state, duration counter, rank index and arm flag.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= RST_HOLD;
      cnt_q   <= 32'd0;
      r_q     <= 2'd0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      arm_q   <= arm_d;
    end
  end

  // Output pin registers; reset forces a quiet bus with RESET# asserted.
  always_ff @(posedge ck) begin
    if (rst) begin
      zq_ack_q      <= 1'b0;
      ddr_reset_n_q <= 1'b0;
      cke_q         <= 1'b0;
      cs_n_q        <= {NUM_RANKS{1'b1}};
      ras_n_q       <= 1'b1;
      cas_n_q       <= 1'b1;
      we_n_q        <= 1'b1;
      ba_q          <= {BA_BITS{1'b0}};
      a_q           <= {ADDR_BITS{1'b0}};
      odt_q         <= 1'b0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      zq_ack_q      <= zq_ack_d;
      ddr_reset_n_q <= ddr_reset_n_d;
      cke_q         <= cke_d;
      cs_n_q        <= cs_n_d;
      ras_n_q       <= ras_n_d;
      cas_n_q       <= cas_n_d;
      we_n_q        <= we_n_d;
      ba_q          <= ba_d;
      a_q           <= a_d;
      odt_q         <= 1'b0;
      init_done_q   <= init_done_d;
      busy_q        <= ~init_done_d;
    end
  end

  assign zq_ack      = zq_ack_q;
  assign ddr_reset_n = ddr_reset_n_q;
  assign cke         = cke_q;
  assign cs_n        = cs_n_q;
  assign ras_n       = ras_n_q;
  assign cas_n       = cas_n_q;
  assign we_n        = we_n_q;
  assign ba          = ba_q;
  assign a           = a_q;
  assign odt         = odt_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Directed bench for ddr3_init_seq with a command/ack scoreboard.
module tb_ddr3_init_seq;

  logic        ck;
  logic        rst;
  logic        init_req;
  logic        zq_req;
  logic        zq_ack;
  logic        ddr_reset_n;
  logic        cke;
  logic [1:0]  cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [2:0]  ba;
  logic [15:0] a;
  logic        odt;
  logic        init_done;
  logic        busy;

  ddr3_init_seq #(
    .ADDR_BITS(16), .BA_BITS(3), .NUM_RANKS(2),
    .T_RESET(4), .T_CKE(6), .T_XPR(5), .T_MRD(4), .T_MOD(12),
    .T_ZQINIT(8), .T_ZQCS(6)
  ) dut (
    .ck(ck), .rst(rst), .init_req(init_req), .zq_req(zq_req), .zq_ack(zq_ack),
    .ddr_reset_n(ddr_reset_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .a(a), .odt(odt),
    .init_done(init_done), .busy(busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    int          cyc;
    logic [23:0] pins;
  } cmd_t;

  cmd_t exp_q[$];
  int   ack_q[$];
  int   tests;
  int   fails;
  int   t;
  int   base;
  int   n;

  function automatic logic [23:0] pk(input logic [1:0] c, input logic [2:0] rcw,
                                     input logic [2:0] b, input logic [15:0] ad);
    return {c, rcw, b, ad};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests = tests + 1;
    assert (obs === expv) else begin
      fails = fails + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_cmd(input int rel, input int lim, input logic [23:0] p);
    cmd_t e;
    if (rel <= lim) begin
      e.cyc  = base + rel;
      e.pins = p;
      exp_q.push_back(e);
    end
  endtask

  // Expected init command stream relative to the current base, up to cycle lim.
  task automatic push_init(input int lim);
    for (int r = 0; r < 2; r++) begin
      int off;
      logic [1:0] c;
      off = 15 + 32 * r;
      c   = (r == 0) ? 2'b10 : 2'b01;
      push_cmd(off,      lim, pk(c, 3'b000, 3'd2, 16'h0000));
      push_cmd(off + 4,  lim, pk(c, 3'b000, 3'd3, 16'h0000));
      push_cmd(off + 8,  lim, pk(c, 3'b000, 3'd1, 16'h0044));
      push_cmd(off + 12, lim, pk(c, 3'b000, 3'd0, 16'h0522));
      push_cmd(off + 24, lim, pk(c, 3'b110, 3'd0, 16'h0400));
    end
  endtask

  task automatic monitor();
    cmd_t e;
    if (odt !== 1'b0) chk("odt_zero", odt, 32'd0);
    if (cs_n == 2'b11) begin
      chk("deselect", {ras_n, cas_n, we_n, ba, a}, {3'b111, 19'd0});
    end else if (!(ras_n && cas_n && we_n)) begin
      if (exp_q.size() == 0) begin
        chk("cmd_unexpected_cyc", t, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_cycle", t, e.cyc);
        chk("cmd_pins", {8'd0, cs_n, ras_n, cas_n, we_n, ba, a}, {8'd0, e.pins});
      end
    end
    if (zq_ack) begin
      if (ack_q.size() == 0) chk("zq_ack_unexpected_cyc", t, 32'd0);
      else                   chk("zq_ack_cycle", t, ack_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge ck);
    t = t + 1;
    @(negedge ck);
    monitor();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rstn"}, ddr_reset_n, 32'd0);
    chk({tag, "_cke"}, cke, 32'd0);
    chk({tag, "_cs_n"}, cs_n, 32'd3);
    chk({tag, "_rcw"}, {ras_n, cas_n, we_n}, 32'd7);
    chk({tag, "_ba"}, ba, 32'd0);
    chk({tag, "_a"}, a, 32'd0);
    chk({tag, "_odt"}, odt, 32'd0);
    chk({tag, "_done"}, init_done, 32'd0);
    chk({tag, "_busy"}, busy, 32'd1);
    chk({tag, "_ack"}, zq_ack, 32'd0);
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; zq_req = 1'b0;
    t = 0; tests = 0; fails = 0; base = 0; n = 0;
    repeat (3) tick();
    chk_reset("por");

    // Full power-up sequence from reset release.
    rst = 1'b0;
    base = t + 1;
    push_init(1000);
    for (int i = 0; i <= 100; i++) begin
      tick();
      n = t - base;
      if (n == 3)  chk("r1_rstn_c3", ddr_reset_n, 32'd0);
      if (n == 4)  chk("r1_rstn_c4", ddr_reset_n, 32'd1);
      if (n == 9)  chk("r1_cke_c9", cke, 32'd0);
      if (n == 10) chk("r1_cke_c10", cke, 32'd1);
      if (n >= 10 && n <= 14) chk("r1_xpr_nop", {cs_n, ras_n, cas_n, we_n}, 32'h07);
      if (n == 78) chk("r1_done_c78", init_done, 32'd0);
      if (n == 79) chk("r1_done_c79", init_done, 32'd1);
      if (n == 79) chk("r1_busy_c79", busy, 32'd0);
    end

    // ZQCS request in DONE.
    zq_req = 1'b1;
    ack_q.push_back(base + 101);
    push_cmd(101, 1000, pk(2'b00, 3'b110, 3'd0, 16'h0000));
    tick();
    zq_req = 1'b0;
    chk("zqcs_done_c101", init_done, 32'd0);
    for (int i = 102; i <= 107; i++) begin
      tick();
      n = t - base;
      if (n <= 106) chk("zqcs_done_low", init_done, 32'd0);
      else          chk("zqcs_done_back", init_done, 32'd1);
    end

    // init_req and zq_req together: re-init wins; zq_req then held through init.
    init_req = 1'b1;
    zq_req = 1'b1;
    base = t + 1;
    push_init(1000);
    ack_q.push_back(base + 80);
    push_cmd(80, 1000, pk(2'b00, 3'b110, 3'd0, 16'h0000));
    tick();
    init_req = 1'b0;
    chk("r2_done_c0", init_done, 32'd0);
    chk("r2_rstn_c0", ddr_reset_n, 32'd0);
    chk("r2_cke_c0", cke, 32'd0);
    for (int i = 1; i <= 86; i++) begin
      tick();
      n = t - base;
      if (n == 3)  chk("r2_rstn_c3", ddr_reset_n, 32'd0);
      if (n == 4)  chk("r2_rstn_c4", ddr_reset_n, 32'd1);
      if (n == 10) chk("r2_cke_c10", cke, 32'd1);
      if (n == 79) chk("r2_done_c79", init_done, 32'd1);
      if (n == 80) chk("r2_done_c80", init_done, 32'd0);
      if (n == 86) chk("r2_done_c86", init_done, 32'd1);
      if (n == 40) init_req = 1'b1;
      if (n == 41) init_req = 1'b0;
      if (n == 80) zq_req = 1'b0;
    end

    // rst from DONE, then rst again in the middle of MOD_WAIT.
    rst = 1'b1;
    tick();
    chk_reset("rst_done");
    rst = 1'b0;
    base = t + 1;
    push_init(30);
    for (int i = 0; i <= 30; i++) tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_mod");
    rst = 1'b0;
    base = t + 1;
    push_init(1000);
    for (int i = 0; i <= 80; i++) begin
      tick();
      n = t - base;
      if (n == 4)  chk("r3_rstn_c4", ddr_reset_n, 32'd1);
      if (n == 79) chk("r3_done_c79", init_done, 32'd1);
    end

    chk("cmd_queue_left", exp_q.size(), 32'd0);
    chk("ack_queue_left", ack_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
